// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port with a PREADY watchdog
module apb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*PADDR_SIZE-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*PDATA_SIZE-1:0]     req_wdata,
  input  logic [NUM_REQ*(PDATA_SIZE/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [PDATA_SIZE-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              PSEL,
  output logic                              PENABLE,
  output logic [PADDR_SIZE-1:0]             PADDR,
  output logic                              PWRITE,
  output logic [PDATA_SIZE/8-1:0]           PSTRB,
  output logic [PDATA_SIZE-1:0]             PWDATA,
  input  logic [PDATA_SIZE-1:0]             PRDATA,
  input  logic                              PREADY,
  input  logic                              PSLVERR
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = PDATA_SIZE / 8;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state;
  logic [IW-1:0] last_gnt, gnt, idx;
  logic          any, wd_hit;
  logic [CW-1:0] wd_cnt;
  always_comb begin
    gnt = last_gnt;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_gnt) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  assign req_ready = (rst && state == IDLE && any) ? NUM_REQ'(1) << gnt : '0;
  assign wd_hit = (TIMEOUT != 0) && (int'(wd_cnt) == TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= IW'(NUM_REQ - 1);
      wd_cnt    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSTRB     <= '0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (any) begin
          state    <= SETUP;
          last_gnt <= gnt;
          wd_cnt   <= '0;
          PSEL     <= 1'b1;
          PADDR    <= req_addr[gnt*PADDR_SIZE +: PADDR_SIZE];
          PWRITE   <= req_write[gnt];
          PWDATA   <= req_wdata[gnt*PDATA_SIZE +: PDATA_SIZE];
          PSTRB    <= req_write[gnt] ? req_strb[gnt*SW +: SW] : '0;
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: if (PREADY || wd_hit) begin
          state     <= IDLE;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= NUM_REQ'(1) << last_gnt;
          rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
          rsp_err   <= PREADY ? PSLVERR : 1'b1;
        end else if (TIMEOUT != 0) wd_cnt <= wd_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench with random requesters and a random-wait APB slave
module tb_apb_master_arbiter;
  localparam int N = 3, AW = 32, DW = 32, SW = 4, TO = 16;
  logic            clk = 1'b0, rst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]   PADDR;
  logic [SW-1:0]   PSTRB;

  typedef struct {int owner; logic [DW-1:0] rdata; logic err; int due;} exp_t;
  exp_t          exp_q[$];
  int            glog[$];
  int            n_cmp = 0, n_bad = 0, cyc = 0, last = N - 1, acc_cyc = 0, force_w = 0;
  bit            busy = 1'b0, fd_en = 1'b0;
  logic [DW-1:0] fd_rd = '0;
  logic          fd_er = 1'b0;
  logic [AW-1:0] cur_a;
  logic          cur_w;
  logic [DW-1:0] cur_d;
  logic [SW-1:0] cur_s;

  apb_master_arbiter #(.NUM_REQ(N), .PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  initial forever #5 clk = ~clk;

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // winner is the valid requester at the smallest circular distance past the last winner
  function automatic int rr_pick(input logic [N-1:0] v, input int lg);
    int best, bd;
    best = -1;
    bd = N;
    for (int j = 0; j < N; j++)
      if (v[j] && ((j - lg - 1 + N) % N) < bd) begin
        bd = (j - lg - 1 + N) % N;
        best = j;
      end
    return best;
  endfunction

  // monitor: reference model of grants, bus phases and responses
  initial begin
    exp_t e;
    int g;
    logic [N-1:0] er;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        busy = 1'b0;
        last = N - 1;
        exp_q.delete();
      end else begin
        if (rsp_valid != 0) begin
          if (exp_q.size() == 0) check("rsp_spurious", 128'(rsp_valid), 128'(0));
          else begin
            e = exp_q.pop_front();
            check("rsp_owner", 128'(rsp_valid), 128'(N'(1) << e.owner));
            check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
            check("rsp_err", 128'(rsp_err), 128'(e.err));
            check("rsp_time", 128'(cyc), 128'(e.due));
          end
          busy = 1'b0;
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("rsp_missing", 128'(rsp_valid), 128'(N'(1) << e.owner));
          busy = 1'b0;
        end
        g = busy ? -1 : rr_pick(req_valid, last);
        er = (g < 0) ? '0 : N'(1) << g;
        check("grant", 128'(req_ready), 128'(er));
        if (busy) begin
          check("bus_phase", 128'({PSEL, PENABLE}), 128'({1'b1, (cyc - acc_cyc) >= 2}));
          check("bus_fields", 128'({PADDR, PWRITE, PWDATA, PSTRB}),
                128'({cur_a, cur_w, cur_d, cur_w ? cur_s : 4'h0}));
        end else check("bus_idle", 128'({PSEL, PENABLE}), 128'(0));
        if (g >= 0) begin
          busy = 1'b1;
          last = g;
          acc_cyc = cyc;
          cur_a = req_addr[g*AW +: AW];
          cur_w = req_write[g];
          cur_d = req_wdata[g*DW +: DW];
          cur_s = req_strb[g*SW +: SW];
          glog.push_back(g);
        end
      end
    end
  end

  // slave: picks a wait count in SETUP and pushes the response the requester must see
  initial begin
    int w, r;
    logic [DW-1:0] rd;
    logic er;
    exp_t e;
    w = 0;
    rd = '0;
    er = 1'b0;
    PREADY = 1'b0;
    PRDATA = '0;
    PSLVERR = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) PREADY = 1'b0;
      else if (PSEL && !PENABLE) begin
        r = int'($urandom_range(99));
        w = force_w >= 0 ? force_w : r < 60 ? 0 : r < 85 ? int'($urandom_range(3, 1)) :
            r < 93 ? int'($urandom_range(16, 15)) : int'($urandom_range(20, 17));
        rd = fd_en ? fd_rd : $urandom;
        er = fd_en ? fd_er : 1'($urandom);
        e.owner = last;
        e.rdata = (w >= TO || cur_w) ? '0 : rd;
        e.err = (w >= TO) ? 1'b1 : er;
        e.due = (w < TO) ? cyc + 3 + w : cyc + 2 + TO;
        exp_q.push_back(e);
        PREADY = 1'b0;
        PRDATA = $urandom;
        PSLVERR = 1'($urandom);
      end else if (PSEL && PENABLE && w == 0) begin
        PREADY = 1'b1;
        PRDATA = rd;
        PSLVERR = er;
      end else begin
        if (PSEL && PENABLE) w--;
        PREADY = 1'b0;
        PRDATA = $urandom;
        PSLVERR = 1'($urandom);
      end
    end
  end

  task automatic rand_fields(input int i);
    req_addr[i*AW +: AW] = $urandom;
    req_write[i] = 1'($urandom);
    req_wdata[i*DW +: DW] = $urandom;
    req_strb[i*SW +: SW] = 4'($urandom);
  endtask

  task automatic drive(input int n, input int rate, input logic [N-1:0] mask, input int drop);
    logic [N-1:0] acc;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = mask[i] && (int'($urandom_range(99)) < rate);
          if (req_valid[i]) rand_fields(i);
        end else if (int'($urandom_range(99)) < drop) req_valid[i] = 1'b0;
    end
  endtask

  task automatic issue(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_write[i] = wr;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    check("accept_wait", 128'(got), 128'(1));
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      #1;
      done = !busy && exp_q.size() == 0;
    end
    check("idle_wait", 128'(done), 128'(1));
  endtask

  initial begin
    int b;
    rst = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb = '0;
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    check("reset_outputs", 128'({PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err}), 128'(0));
    req_valid = '0;
    #1 rst = 1'b1;
    b = glog.size();
    drive(16, 100, 3'b011, 0);
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 4; k++) check("rr_alternate", 128'((b + k < glog.size()) ? glog[b+k] : -1), 128'(k % 2));
    fd_en = 1'b1;
    fd_rd = 32'hCAFE_F00D;
    fd_er = 1'b0;
    issue(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
    wait_idle();
    force_w = 3;
    fd_rd = 32'h1234;
    fd_er = 1'b1;
    issue(1, 32'h2000_0040, 1'b0, 32'h5555_AAAA, 4'hA);
    wait_idle();
    fd_en = 1'b0;
    force_w = 40;
    issue(2, 32'h3000_0000, 1'b0, 32'h0, 4'h0);
    wait_idle();
    force_w = 0;
    issue(0, 32'h44, 1'b0, 32'h0, 4'h3);
    wait_idle();
    force_w = 15;
    issue(1, 32'h48, 1'b1, 32'h0102_0304, 4'h5);
    wait_idle();
    force_w = 16;
    issue(2, 32'h4C, 1'b0, 32'h0, 4'h0);
    wait_idle();
    force_w = -1;
    drive(3000, 30, '1, 5);
    req_valid = '0;
    wait_idle();
    force_w = 40;
    issue(1, 32'h50, 1'b1, 32'h7777_0000, 4'hC);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    req_valid = '1;
    #1;
    check("async_reset", 128'({PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err}), 128'(0));
    @(negedge clk);
    #1;
    req_valid = '0;
    #1 rst = 1'b1;
    force_w = 0;
    @(posedge clk);
    #1;
    req_valid = '1;
    @(negedge clk);
    #1;
    check("post_reset_grant", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
